// File: rtl/tlc5955_rx.sv
// tlc5955_rx: receiver/emulator for the TLC5955 4-wire serial interface.
// The four input lines are oversampled in the clk domain. 769-bit words are
// shifted in MSB first, and each word is decoded on LAT into either the
// control latch or the grayscale latch.
// Optional 48-channel PWM engine clocked by gsclk edges: define TLC_RX_PWM_EN.
// Without it, gs_cnt and pwm_out are tied to zero and gsclk is unused.

module tlc5955_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  CMD_WORD    = 8'h96
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sin,
    input  logic         sclk,
    input  logic         lat,
    input  logic         gsclk,
    input  logic [3:0]   ch_sel,
    output logic         ctrl_valid,
    output logic         gs_valid,
    output logic         frame_err,
    output logic [4:0]   fc,
    output logic [20:0]  bc,
    output logic [8:0]   mc,
    output logic [335:0] dc,
    output logic [15:0]  gs_r,
    output logic [15:0]  gs_g,
    output logic [15:0]  gs_b,
    output logic [15:0]  gs_cnt,
    output logic [47:0]  pwm_out
);

    localparam logic [9:0] FRAME_LEN = 10'd769;
    localparam logic [9:0] CNT_MAX   = 10'd1023;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DECODE
    } state_t;

    state_t         state;
    logic [768:0]   sr;
    logic [9:0]     bit_cnt;
    logic [767:0]   gs_latch;

    // Synchronizer chains. sclk and lat carry one extra stage, which holds
    // the previous synchronized sample for rising-edge detection.
    logic [SYNC_STAGES-1:0] sin_q;
    logic [SYNC_STAGES:0]   sclk_q;
    logic [SYNC_STAGES:0]   lat_q;

    logic sin_s;
    logic sclk_rise;
    logic lat_rise;
    logic [9:0] bit_cnt_inc;

    // Input synchronizers for sin, sclk and lat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_q  <= '0;
            sclk_q <= '0;
            lat_q  <= '0;
        end else begin
            sin_q  <= {sin_q[SYNC_STAGES-2:0], sin};
            sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
            lat_q  <= {lat_q[SYNC_STAGES-1:0], lat};
        end
    end

    assign sin_s       = sin_q[SYNC_STAGES-1];
    assign sclk_rise   = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign lat_rise    = lat_q[SYNC_STAGES-1] & ~lat_q[SYNC_STAGES];
    assign bit_cnt_inc = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 10'd1;

    // Receive FSM: shift, latch-detect, decode, and registered result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            ctrl_valid <= 1'b0;
            gs_valid   <= 1'b0;
            frame_err  <= 1'b0;
            fc         <= '0;
            bc         <= '0;
            mc         <= '0;
            dc         <= '0;
            gs_latch   <= '0;
        end else begin
            ctrl_valid <= 1'b0;
            gs_valid   <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sclk_rise) begin
                        // A coincident lat edge takes this bit in first, then decodes.
                        sr      <= {sr[767:0], sin_s};
                        bit_cnt <= bit_cnt_inc;
                        state   <= lat_rise ? DECODE : SHIFT;
                    end else if (lat_rise) begin
                        frame_err <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        sr      <= {sr[767:0], sin_s};
                        bit_cnt <= bit_cnt_inc;
                    end
                    if (lat_rise) begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (bit_cnt != FRAME_LEN) begin
                        frame_err <= 1'b1;
                    end else if (sr[768] && (sr[767:760] == CMD_WORD)) begin
                        fc         <= sr[370:366];
                        bc         <= sr[365:345];
                        mc         <= sr[344:336];
                        dc         <= sr[335:0];
                        ctrl_valid <= 1'b1;
                    end else if (sr[768]) begin
                        frame_err <= 1'b1;
                    end else begin
                        gs_latch <= sr[767:0];
                        gs_valid <= 1'b1;
                    end
                    sr      <= '0;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic [9:0] rd_base;

    // Bit offset of the selected LED within the grayscale latch.
    always_comb begin
        rd_base = 10'd0;
        rd_base = {6'd0, ch_sel} * 10'd48;
    end

    // Registered grayscale readback for LED ch_sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gs_r <= '0;
            gs_g <= '0;
            gs_b <= '0;
        end else begin
            gs_r <= gs_latch[rd_base +: 16];
            gs_g <= gs_latch[rd_base + 10'd16 +: 16];
            gs_b <= gs_latch[rd_base + 10'd32 +: 16];
        end
    end

`ifdef TLC_RX_PWM_EN
    logic [SYNC_STAGES:0] gsclk_q;
    logic gsclk_rise;
    logic gs_load;

    // gsclk synchronizer with one extra stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gsclk_q <= '0;
        end else begin
            gsclk_q <= {gsclk_q[SYNC_STAGES-1:0], gsclk};
        end
    end

    assign gsclk_rise = gsclk_q[SYNC_STAGES-1] & ~gsclk_q[SYNC_STAGES];
    // True in the DECODE cycle that commits a grayscale word, so the counter
    // reads zero in the same cycle that gs_valid is asserted.
    assign gs_load    = (state == DECODE) && (bit_cnt == FRAME_LEN) && !sr[768];

    // Grayscale counter: restarts on a new GS word, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gs_cnt <= '0;
        end else if (gs_load) begin
            gs_cnt <= '0;
        end else if (gsclk_rise) begin
            gs_cnt <= gs_cnt + 16'd1;
        end
    end

    // Channel k occupies latch bits [16k+15:16k]. Its output is high while the value exceeds the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else begin
            for (int unsigned k = 0; k < 48; k++) begin
                pwm_out[k] <= (gs_latch[16*k +: 16] > gs_cnt);
            end
        end
    end
`else
    logic unused_gsclk;

    assign unused_gsclk = gsclk;
    assign gs_cnt       = '0;
    assign pwm_out      = '0;
`endif

endmodule

// File: tb/tb_tlc5955_rx.sv
// tb_tlc5955_rx: self-checking bench for tlc5955_rx.
// It uses directed frames from the usage scenarios and then randomized
// frames. All frames are checked against a field-level reference model.
// The PWM checks apply when TLC_RX_PWM_EN is defined.

module tb_tlc5955_rx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sin;
    logic         sclk;
    logic         lat;
    logic         gsclk;
    logic [3:0]   ch_sel;
    logic         ctrl_valid;
    logic         gs_valid;
    logic         frame_err;
    logic [4:0]   fc;
    logic [20:0]  bc;
    logic [8:0]   mc;
    logic [335:0] dc;
    logic [15:0]  gs_r;
    logic [15:0]  gs_g;
    logic [15:0]  gs_b;
    logic [15:0]  gs_cnt;
    logic [47:0]  pwm_out;

    tlc5955_rx #(
        .SYNC_STAGES(2),
        .CMD_WORD   (8'h96)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sclk      (sclk),
        .lat       (lat),
        .gsclk     (gsclk),
        .ch_sel    (ch_sel),
        .ctrl_valid(ctrl_valid),
        .gs_valid  (gs_valid),
        .frame_err (frame_err),
        .fc        (fc),
        .bc        (bc),
        .mc        (mc),
        .dc        (dc),
        .gs_r      (gs_r),
        .gs_g      (gs_g),
        .gs_b      (gs_b),
        .gs_cnt    (gs_cnt),
        .pwm_out   (pwm_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: latched fields, 48 grayscale channels, PWM count.
    logic [4:0]   m_fc;
    logic [20:0]  m_bc;
    logic [8:0]   m_mc;
    logic [335:0] m_dc;
    logic [15:0]  m_gs [48];
    int           m_cnt;

    // Candidate payload for the next frame.
    logic [4:0]   c_fc;
    logic [20:0]  c_bc;
    logic [8:0]   c_mc;
    logic [335:0] c_dc;
    logic [15:0]  c_gs [48];

    task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [768:0] ctrl_frame(input logic [7:0] cmd);
        return {1'b1, cmd, 389'd0, c_fc, c_bc, c_mc, c_dc};
    endfunction

    function automatic logic [768:0] gs_frame();
        logic [768:0] w;
        w = '0;
        for (int k = 0; k < 48; k++) w[16*k +: 16] = c_gs[k];
        return w;
    endfunction

    // 0 = grayscale accepted, 1 = control accepted, 2 = frame error.
    function automatic int expect_kind(input logic [768:0] w, input int n);
        if (n != 769) return 2;
        if (w[768] && w[767:760] == 8'h96) return 1;
        if (w[768]) return 2;
        return 0;
    endfunction

    task automatic rand_ctrl();
        c_fc = 5'($urandom);
        c_bc = 21'($urandom);
        c_mc = 9'($urandom);
        for (int i = 0; i < 336; i++) c_dc[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_gs();
        for (int k = 0; k < 48; k++) c_gs[k] = 16'($urandom);
    endtask

    // Sends the low n bits of w MSB first. Bit positions above 768 are sent as 0.
    task automatic send_frame(input logic [768:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (i < 769) sin = w[i];
            else sin = 1'b0;
            sclk = 1'b0;
            @(negedge clk);
            sclk = 1'b1;
            @(negedge clk);
        end
        sclk = 1'b0;
        sin  = 1'b1;
        @(negedge clk);
    endtask

    // Raises lat for one clk period and counts result pulses over a bounded window.
    task automatic latch_observe(output int nc, output int ng, output int ne, output int first);
        nc = 0; ng = 0; ne = 0; first = 0;
        lat = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) lat = 1'b0;
            if (first == 0 && (ctrl_valid || gs_valid || frame_err)) first = i;
            nc += int'(ctrl_valid);
            ng += int'(gs_valid);
            ne += int'(frame_err);
        end
    endtask

    task automatic check_pwm(input string tag);
        logic [47:0] e;
        for (int k = 0; k < 48; k++) begin
`ifdef TLC_RX_PWM_EN
            e[k] = (int'(m_gs[k]) > m_cnt);
`else
            e[k] = 1'b0;
`endif
        end
`ifdef TLC_RX_PWM_EN
        check({tag, "_gs_cnt"}, 768'(gs_cnt), 768'(m_cnt));
`else
        check({tag, "_gs_cnt"}, 768'(gs_cnt), 768'(0));
`endif
        check({tag, "_pwm"}, 768'(pwm_out), 768'(e));
    endtask

    task automatic check_state(input string tag);
        check({tag, "_fc"}, 768'(fc), 768'(m_fc));
        check({tag, "_bc"}, 768'(bc), 768'(m_bc));
        check({tag, "_mc"}, 768'(mc), 768'(m_mc));
        check({tag, "_dc"}, 768'(dc), 768'(m_dc));
        for (int j = 0; j < 2; j++) begin
            int ch;
            ch = $urandom_range(0, 15);
            ch_sel = 4'(ch);
            @(negedge clk);
            @(negedge clk);
            check({tag, "_gs_r"}, 768'(gs_r), 768'(m_gs[3*ch]));
            check({tag, "_gs_g"}, 768'(gs_g), 768'(m_gs[3*ch+1]));
            check({tag, "_gs_b"}, 768'(gs_b), 768'(m_gs[3*ch+2]));
        end
        check_pwm(tag);
    endtask

    // Sends a frame, latches it, checks the pulses, then updates the model and checks the latches.
    task automatic run_frame(input string tag, input logic [768:0] w, input int n);
        int nc, ng, ne, first, kind;
        send_frame(w, n);
        latch_observe(nc, ng, ne, first);
        kind = expect_kind(w, n);
        check({tag, "_ctrl_pulses"}, 768'(nc), 768'(kind == 1));
        check({tag, "_gs_pulses"}, 768'(ng), 768'(kind == 0));
        check({tag, "_err_pulses"}, 768'(ne), 768'(kind == 2));
        check({tag, "_latency"}, 768'(first), 768'(4));
        if (kind == 1) begin
            m_fc = c_fc; m_bc = c_bc; m_mc = c_mc; m_dc = c_dc;
        end else if (kind == 0) begin
            for (int k = 0; k < 48; k++) m_gs[k] = c_gs[k];
            m_cnt = 0;
        end
        check_state(tag);
    endtask

    task automatic gsclk_edge();
        gsclk = 1'b1;
        @(negedge clk);
        gsclk = 1'b0;
        repeat (3) @(negedge clk);
        m_cnt = (m_cnt + 1) % 65536;
    endtask

    task automatic model_reset();
        m_fc = '0; m_bc = '0; m_mc = '0; m_dc = '0; m_cnt = 0;
        for (int k = 0; k < 48; k++) m_gs[k] = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulses"}, 768'({ctrl_valid, gs_valid, frame_err}), 768'(0));
        check({tag, "_ctrl"}, 768'({fc, bc, mc, dc}), 768'(0));
        check({tag, "_gsrd"}, 768'({gs_r, gs_g, gs_b}), 768'(0));
        check({tag, "_pwm"}, 768'({gs_cnt, pwm_out}), 768'(0));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [768:0] w;
        int nc, ng, ne, first;

        rst_n = 1'b0; sin = 1'b1; sclk = 1'b0; lat = 1'b0; gsclk = 1'b0; ch_sel = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed control write.
        c_fc = 5'b01001; c_bc = '1; c_mc = '1; c_dc = '1;
        run_frame("ctrl_dir", ctrl_frame(8'h96), 769);
        check("ctrl_dir_fc_const", 768'(fc), 768'(5'h09));

        // Directed grayscale write: r = 1, g = 2, b = 3 for every LED.
        for (int n = 0; n < 16; n++) begin
            c_gs[3*n] = 16'd1; c_gs[3*n+1] = 16'd2; c_gs[3*n+2] = 16'd3;
        end
        run_frame("gs_dir", gs_frame(), 769);
        ch_sel = 4'd7;
        repeat (2) @(negedge clk);
        check("gs_dir_ch7_r", 768'(gs_r), 768'(1));
        check("gs_dir_ch7_g", 768'(gs_g), 768'(2));
        check("gs_dir_ch7_b", 768'(gs_b), 768'(3));
        check("gs_dir_fc_kept", 768'(fc), 768'(5'h09));

        // Four gsclk edges after the grayscale write.
        for (int e = 0; e < 4; e++) begin
            gsclk_edge();
            check_pwm("pwm_step");
        end

        // Short frame, then a good frame.
        rand_ctrl();
        run_frame("short", ctrl_frame(8'h96), 768);
        rand_gs();
        run_frame("after_short", gs_frame(), 769);

        // Bad command byte.
        rand_ctrl();
        run_frame("bad_cmd", ctrl_frame(8'h95), 769);

        // Counter saturation: 1793 bits must not wrap back to 769.
        rand_ctrl();
        run_frame("saturate", ctrl_frame(8'h96), 1793);

        // Lat with no preceding bits.
        latch_observe(nc, ng, ne, first);
        check("idle_lat_err", 768'(ne), 768'(1));
        check("idle_lat_ctrl", 768'(nc + ng), 768'(0));
        check_state("idle_lat");

        // Two identical control writes each pulse ctrl_valid.
        rand_ctrl();
        run_frame("repeat1", ctrl_frame(8'h96), 769);
        run_frame("repeat2", ctrl_frame(8'h96), 769);

        // Randomized frames.
        for (int t = 0; t < 6; t++) begin
            int sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin rand_gs(); run_frame("rnd_gs", gs_frame(), 769); end
                1: begin rand_ctrl(); run_frame("rnd_ctrl", ctrl_frame(8'h96), 769); end
                2: begin
                    logic [7:0] cmd;
                    cmd = 8'($urandom);
                    if (cmd == 8'h96) cmd = 8'h97;
                    rand_ctrl();
                    run_frame("rnd_badcmd", ctrl_frame(cmd), 769);
                end
                default: begin
                    int lens [4];
                    lens = '{768, 770, 500, 1030};
                    rand_gs();
                    w = gs_frame();
                    run_frame("rnd_badlen", w, lens[$urandom_range(0, 3)]);
                end
            endcase
            if (sel == 0) begin
                gsclk_edge();
                gsclk_edge();
                check_pwm("rnd_pwm");
            end
        end

        // Reset mid-frame.
        rand_ctrl();
        send_frame(ctrl_frame(8'h96), 300);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("post_reset");
        run_frame("post_reset_ctrl", ctrl_frame(8'h96), 769);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlc5955_rx.md
Name: tlc5955_rx

Overview:
- Receiver/emulator for the TLC5955 4-wire serial interface (SOUT, SCLK, LAT, GSCLK). It is the far end of the existing single-chip TLC5955 transmitter.
- Oversamples the four lines in the `clk` domain and shifts in 769-bit words MSB first. On LAT it decodes each word into the control latch or the grayscale latch.
- Optionally runs a 48-channel PWM engine clocked by GSCLK edges.
- Used as a board-less loopback target in simulation and on FPGA, so transmitter output can be checked bit-exact.

Parameters:
- SYNC_STAGES, 2, flip-flop synchronizer depth on each of the four inputs (minimum 2).
- CMD_WORD, 8'h96, control-write command byte expected in bits [767:760].

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sin  in  1  serial data (line is pulled up; transmitter drives 0 or Z).
- sclk  in  1  shift clock.
- lat  in  1  latch strobe.
- gsclk  in  1  grayscale PWM clock.
- ch_sel  in  4  LED index 0..15 for the gs_r/gs_g/gs_b readback.
- ctrl_valid  out  1  one-cycle pulse: control latch updated.
- gs_valid  out  1  one-cycle pulse: grayscale latch updated.
- frame_err  out  1  one-cycle pulse: word discarded.
- fc  out  5  function control, word bits [370:366].
- bc  out  21  global brightness, bits [365:345].
- mc  out  9  max current, bits [344:336].
- dc  out  336  dot correction, bits [335:0].
- gs_r  out  16  grayscale of LED ch_sel, red.
- gs_g  out  16  grayscale of LED ch_sel, green.
- gs_b  out  16  grayscale of LED ch_sel, blue.
- gs_cnt  out  16  current GSCLK count.
- pwm_out  out  48  channel PWM: index 3n+0 = R, 3n+1 = G, 3n+2 = B of LED n.

Behaviour:
- Reset (async assert, sync deassert) clears every output, every latch, the shift register, the bit counter and the FSM (state → IDLE).
- Each input passes through SYNC_STAGES flops. Rising edges of sclk, lat and gsclk are detected from the last two synchronized samples.
- Input timing: each line level must be held ≥1 clk period when the source shares clk; asynchronous sources need clk ≥ 4× the sclk rate.
- sin is sampled on the same cycle the sclk rising edge is detected. Shift: sr <= {sr[767:0], sin}, 769 bits.
- bit_cnt is 10 bits. It increments per sclk edge and saturates at 1023.
- FSM states:
  - IDLE: first sclk edge → SHIFT.
  - SHIFT: lat edge → DECODE.
  - DECODE: single cycle, then → IDLE with sr/bit_cnt cleared.
- A lat edge seen in IDLE (bit_cnt = 0) gives frame_err and no update.
- DECODE, evaluated in this order:
  - bit_cnt ≠ 769 → frame_err.
  - sr[768] = 1 and sr[767:760] = CMD_WORD → load fc/bc/mc/dc, pulse ctrl_valid.
  - sr[768] = 1 with any other command → frame_err.
  - sr[768] = 0 → load gs_latch[767:0], pulse gs_valid.
- Pulse timing: all pulses and latch updates land on the cycle after DECODE. Latency from synchronized lat edge to pulse is 2 clk.
- GS layout: LED n uses R = [48n+15:48n], G = [48n+31:48n+16], B = [48n+47:48n+32].
- gs_r/gs_g/gs_b are a registered mux on ch_sel, 1 cycle latency.
- An sclk edge coincident with a lat edge is shifted first, then latched.
- A lat edge arriving during DECODE is ignored.
- Control latch persists across GS writes. Repeated identical control writes each pulse ctrl_valid.

Optional Feature:
- Macro: TLC_RX_PWM_EN.
- Defined:
  - gs_cnt increments on each gsclk edge and wraps 65535 → 0.
  - gs_cnt clears to 0 on the gs_valid cycle.
  - pwm_out[k] = (gs value of channel k > gs_cnt), registered.
  - Value 0 is always off. Value 65535 is on for 65535 of 65536 counts.
- Undefined: gs_cnt and pwm_out are tied to 0, and the gsclk synchronizer is omitted.

Test Plan:
- Control write: shift 769 bits {1, 8'h96, 389×0, 5'b01001, 21×1, 9×1, 336×1}, then lat → ctrl_valid one pulse; fc = 5'h09, bc = 21'h1FFFFF, mc = 9'h1FF, dc all ones.
- GS write: {0, 16×{b = 16'h0003, g = 16'h0002, r = 16'h0001}} with ch_sel = 7 → gs_valid; gs_r = 1, gs_g = 2, gs_b = 3; fc unchanged.
- Short frame: 768 sclk edges then lat → frame_err, both latches unchanged. A subsequent good 769-bit frame is accepted.
- Bad command: MSB 1 with command 8'h95 → frame_err, no ctrl_valid.
- PWM (TLC_RX_PWM_EN): after the GS write above, apply 4 gsclk edges:
  - pwm_out[0] (value 1) is high only at gs_cnt = 0.
  - pwm_out[2] (value 3) is high for gs_cnt 0..2.
  - gs_cnt = 4.
- Reset mid-frame: assert rst_n low after 300 bits → all outputs 0 asynchronously. After release, a full control frame decodes correctly.
